calc_sequencer: RTL and testbench

//  Control FSM for the desk-calculator datapath. Edge-detects the keypad and the

---
 rtl/calc_sequencer_if.sv | 33 +++
 rtl/calc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_calc_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: keypad, display and shared-adder signals of the calculator sequencer.
`default_nettype none

interface calc_sequencer_if #(
   parameter int W = 32
);
   logic [15:0]  keys;
   logic         clear;
   logic         plus;
   logic         minus;
   logic         equal;
   logic [W-1:0] ibuf;
   logic [W-1:0] cbuf;
   logic         ovf;
   logic         busy;
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic         add_cin;
   logic [W-1:0] add_sum;
   logic         add_cout;

   modport master (
      input  keys, clear, plus, minus, equal, add_sum, add_cout,
      output ibuf, cbuf, ovf, busy, add_a, add_b, add_cin
   );

   modport slave (
      output keys, clear, plus, minus, equal, add_sum, add_cout,
      input  ibuf, cbuf, ovf, busy, add_a, add_b, add_cin
   );
endinterface

`default_nettype wire

// File: rtl/calc_sequencer.sv
// calc_sequencer: desk-calculator control FSM; edge-detects keys, builds hex operands
// and sequences an external adder for chained add/subtract into an accumulator.
`default_nettype none

module calc_sequencer #(
   parameter int DIGITS  = 8,
   parameter int ADD_LAT = 1
) (
   input  wire logic          clock_i,
   input  wire logic          reset_i,
   calc_sequencer_if.master   bus
);
   localparam int W  = 4 * DIGITS;
   localparam int NW = $clog2(DIGITS + 1);
   localparam int CW = $clog2(ADD_LAT + 2);
   localparam logic [NW-1:0] MAX_DIG = NW'(DIGITS);
   localparam logic [CW-1:0] LAT_CAP = CW'(ADD_LAT);
   localparam logic [CW-1:0] LAT_END = CW'(ADD_LAT + 1);

   typedef enum logic [1:0] {IDLE, ENTRY, ISSUE, WAIT} state_e;
   typedef enum logic [1:0] {P_NONE, P_ADD, P_SUB}     pend_e;

   state_e         state_q;
   pend_e          pend_q;
   pend_e          nxt_pend_q;
   logic [NW-1:0]  ndig_q;
   logic [W-1:0]   ibuf_q;
   logic [W-1:0]   cbuf_q;
   logic           ovf_q;
   logic           busy_q;
   logic [W-1:0]   add_a_q;
   logic [W-1:0]   add_b_q;
   logic           add_cin_q;
   logic           sub_q;
   logic [CW-1:0]  cnt_q;
   logic           keys_any_q;
   logic           plus_q;
   logic           minus_q;
   logic           equal_q;

   logic           keys_any_d;
   logic           digit_ev_d;
   logic           plus_ev_d;
   logic           minus_ev_d;
   logic           equal_ev_d;
   logic           op_ev_d;
   logic [3:0]     digit_d;
   pend_e          op_pend_d;

   assign keys_any_d = |bus.keys;
   assign digit_ev_d = keys_any_d & ~keys_any_q;
   assign plus_ev_d  = bus.plus  & ~plus_q;
   assign minus_ev_d = bus.minus & ~minus_q;
   assign equal_ev_d = bus.equal & ~equal_q;
   assign op_ev_d    = plus_ev_d | minus_ev_d | equal_ev_d;

   // Scan from the top so the lowest set key bit wins.
   always_comb begin
      digit_d = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (bus.keys[i]) digit_d = 4'(i);
      end
   end

   always_comb begin
      op_pend_d = P_SUB;
      if (equal_ev_d)     op_pend_d = P_NONE;
      else if (plus_ev_d) op_pend_d = P_ADD;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         pend_q     <= P_NONE;
         nxt_pend_q <= P_NONE;
         ndig_q     <= '0;
         ibuf_q     <= '0;
         cbuf_q     <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         add_a_q    <= '0;
         add_b_q    <= '0;
         add_cin_q  <= 1'b0;
         sub_q      <= 1'b0;
         cnt_q      <= '0;
         keys_any_q <= 1'b1;
         plus_q     <= 1'b1;
         minus_q    <= 1'b1;
         equal_q    <= 1'b1;
      end else begin
         keys_any_q <= keys_any_d;
         plus_q     <= bus.plus;
         minus_q    <= bus.minus;
         equal_q    <= bus.equal;
         if (bus.clear) begin
            state_q <= IDLE;
            pend_q  <= P_NONE;
            ndig_q  <= '0;
            ibuf_q  <= '0;
            cbuf_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE, ENTRY: begin
                  if (op_ev_d) begin
                     if (pend_q == P_NONE) begin
                        // With no operand typed, keep the accumulator so a result can be chained.
                        if (ndig_q != '0) cbuf_q <= ibuf_q;
                        ibuf_q  <= '0;
                        ndig_q  <= '0;
                        pend_q  <= op_pend_d;
                        state_q <= IDLE;
                     end else begin
                        add_a_q    <= cbuf_q;
                        add_b_q    <= (pend_q == P_SUB) ? ~ibuf_q : ibuf_q;
                        add_cin_q  <= (pend_q == P_SUB);
                        sub_q      <= (pend_q == P_SUB);
                        nxt_pend_q <= op_pend_d;
                        busy_q     <= 1'b1;
                        cnt_q      <= CW'(1);
                        state_q    <= ISSUE;
                     end
                  end else if (digit_ev_d) begin
                     if (ndig_q < MAX_DIG) begin
                        ibuf_q <= (ibuf_q << 4) | W'(digit_d);
                        ndig_q <= ndig_q + NW'(1);
                     end
                     state_q <= ENTRY;
                  end
               end
               ISSUE, WAIT: begin
                  if (cnt_q == LAT_CAP) begin
                     cbuf_q <= bus.add_sum;
                     ovf_q  <= ovf_q | (sub_q ? ~bus.add_cout : bus.add_cout);
                     ibuf_q <= '0;
                     ndig_q <= '0;
                     pend_q <= nxt_pend_q;
                  end
                  if (cnt_q == LAT_END) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     cnt_q   <= cnt_q + CW'(1);
                     state_q <= WAIT;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.ibuf    = ibuf_q;
   assign bus.cbuf    = cbuf_q;
   assign bus.ovf     = ovf_q;
   assign bus.busy    = busy_q;
   assign bus.add_a   = add_a_q;
   assign bus.add_b   = add_b_q;
   assign bus.add_cin = add_cin_q;
endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed scenarios plus random key sequences against a calculator model.
`default_nettype none

module tb_calc_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   calc_sequencer_if #(.W(32)) bus ();

   calc_sequencer #(.DIGITS(8), .ADD_LAT(1)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   // External combinational adder.
   assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};

   int total = 0;
   int bad   = 0;

   // Calculator model: pend 0=none 1=add 2=sub
   logic [31:0] m_ibuf, m_cbuf;
   logic        m_ovf;
   int          m_pend, m_ndig;

   task automatic m_clear();
      m_ibuf = 0; m_cbuf = 0; m_ovf = 0; m_pend = 0; m_ndig = 0;
   endtask

   task automatic m_digit(input int d);
      if (m_ndig < 8) begin
         m_ibuf = (m_ibuf << 4) | 32'(d);
         m_ndig++;
      end
   endtask

   // o: 0 '+', 1 '-', 2 '='
   task automatic m_op(input int o);
      logic [32:0] s;
      if (m_pend == 0) begin
         if (m_ndig > 0) m_cbuf = m_ibuf;
      end else if (m_pend == 1) begin
         s = {1'b0, m_cbuf} + {1'b0, m_ibuf};
         if (s[32]) m_ovf = 1;
         m_cbuf = s[31:0];
      end else begin
         if (m_ibuf > m_cbuf) m_ovf = 1;
         m_cbuf = m_cbuf - m_ibuf;
      end
      m_ibuf = 0;
      m_ndig = 0;
      m_pend = (o == 2) ? 0 : (o == 0 ? 1 : 2);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int o, input logic v);
      case (o)
         0: bus.plus  = v;
         1: bus.minus = v;
         default: bus.equal = v;
      endcase
   endtask

   task automatic press_digit(input int d);
      int extra;
      extra = int'($urandom) & ~((2 << d) - 1) & 16'hFFFF;
      bus.keys = 16'((1 << d) | extra);
      tick();
      bus.keys = 16'h0;
      tick();
      m_digit(d);
   endtask

   task automatic press_op(input int o);
      int n;
      set_op(o, 1'b1);
      tick();
      set_op(o, 1'b0);
      n = 0;
      while (bus.busy && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (bus.busy) begin
         bad++;
         $display("FAIL busy_timeout: busy=%b after %0d cycles, want 0", bus.busy, n);
      end
      tick();
      m_op(o);
   endtask

   task automatic press_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      tick();
      m_clear();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.keys = 16'h0020;
      bus.clear = 0; bus.plus = 0; bus.minus = 0; bus.equal = 0;
      tick(); tick();
      rst = 1'b0;
      tick();
      total++;
      if ({bus.ibuf, bus.cbuf, bus.ovf, bus.busy} !== 66'd0) begin
         bad++;
         $display("FAIL reset_outputs: got ibuf=%h cbuf=%h ovf=%b busy=%b want all 0",
                  bus.ibuf, bus.cbuf, bus.ovf, bus.busy);
      end
      total++;
      if ({bus.add_a, bus.add_b, bus.add_cin} !== 65'd0) begin
         bad++;
         $display("FAIL reset_adder: got a=%h b=%h cin=%b want 0", bus.add_a, bus.add_b, bus.add_cin);
      end
      bus.keys = 16'h0;
      tick();
      total++;
      if (bus.ibuf !== 32'h0) begin
         bad++;
         $display("FAIL reset_held_key: got ibuf=%h want 0", bus.ibuf);
      end
      m_clear();
   endtask

   task automatic test_digits();
      logic [31:0] exp_i [3];
      exp_i[0] = 32'h1; exp_i[1] = 32'h12; exp_i[2] = 32'h123;
      for (int k = 0; k < 3; k++) begin
         press_digit(k + 1);
         total++;
         if (bus.ibuf !== exp_i[k]) begin
            bad++;
            $display("FAIL digit_%0d: got ibuf=%h want %h", k, bus.ibuf, exp_i[k]);
         end
      end
      bus.plus = 1'b1;
      tick();
      total++;
      if (bus.cbuf !== 32'h123 || bus.ibuf !== 32'h0) begin
         bad++;
         $display("FAIL plus_noadder: got cbuf=%h ibuf=%h want 123/0", bus.cbuf, bus.ibuf);
      end
      bus.plus = 1'b0;
      tick();
      m_op(0);
   endtask

   task automatic test_add();
      press_digit(0); press_digit(15); press_digit(15);
      bus.equal = 1'b1;
      tick();
      bus.equal = 1'b0;
      total++;
      if (bus.busy !== 1'b1 || bus.add_a !== 32'h123 || bus.add_b !== 32'h0FF || bus.add_cin !== 1'b0) begin
         bad++;
         $display("FAIL add_issue: got busy=%b a=%h b=%h cin=%b want 1/123/0ff/0",
                  bus.busy, bus.add_a, bus.add_b, bus.add_cin);
      end
      tick();
      total++;
      if (bus.cbuf !== 32'h222 || bus.busy !== 1'b1 || bus.ovf !== 1'b0) begin
         bad++;
         $display("FAIL add_result: got cbuf=%h busy=%b ovf=%b want 222/1/0", bus.cbuf, bus.busy, bus.ovf);
      end
      tick();
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL add_busy_len: got busy=%b want 0 after 2 cycles", bus.busy);
      end
      tick();
      m_op(2);
   endtask

   task automatic test_overflow();
      press_clear();
      for (int k = 0; k < 8; k++) press_digit(15);
      press_op(0);
      press_digit(2);
      press_op(2);
      total++;
      if (bus.cbuf !== 32'h1 || bus.ovf !== 1'b1) begin
         bad++;
         $display("FAIL ovf_add: got cbuf=%h ovf=%b want 00000001/1", bus.cbuf, bus.ovf);
      end
      press_op(1);
      press_digit(5);
      press_op(2);
      total++;
      if (bus.cbuf !== 32'hFFFFFFFC || bus.ovf !== 1'b1) begin
         bad++;
         $display("FAIL ovf_sub: got cbuf=%h ovf=%b want fffffffc/1", bus.cbuf, bus.ovf);
      end
      press_clear();
      total++;
      if (bus.ovf !== 1'b0 || bus.cbuf !== 32'h0) begin
         bad++;
         $display("FAIL ovf_clear: got ovf=%b cbuf=%h want 0/0", bus.ovf, bus.cbuf);
      end
   endtask

   task automatic test_limit_priority();
      for (int k = 0; k < 9; k++) press_digit(10);
      total++;
      if (bus.ibuf !== 32'hAAAAAAAA) begin
         bad++;
         $display("FAIL digit_limit: got ibuf=%h want aaaaaaaa", bus.ibuf);
      end
      bus.plus = 1'b1; bus.minus = 1'b1;
      tick();
      bus.plus = 1'b0; bus.minus = 1'b0;
      tick();
      m_op(0);
      press_digit(1);
      press_op(2);
      total++;
      if (bus.cbuf !== 32'hAAAAAAAB) begin
         bad++;
         $display("FAIL plus_over_minus: got cbuf=%h want aaaaaaab", bus.cbuf);
      end
      // equal and a digit together: digit dropped
      bus.equal = 1'b1; bus.keys = 16'h0008;
      tick();
      bus.equal = 1'b0; bus.keys = 16'h0;
      tick();
      m_op(2);
      total++;
      if (bus.ibuf !== 32'h0) begin
         bad++;
         $display("FAIL equal_over_digit: got ibuf=%h want 0", bus.ibuf);
      end
   endtask

   task automatic test_clear_busy();
      press_clear();
      press_digit(5); press_op(0); press_digit(3);
      bus.equal = 1'b1;
      tick();
      bus.equal = 1'b0;
      bus.keys = 16'h0080;
      tick(); tick();
      m_op(2);
      total++;
      if (bus.busy !== 1'b0 || bus.ibuf !== 32'h0 || bus.cbuf !== 32'h8) begin
         bad++;
         $display("FAIL busy_digit_drop: got busy=%b ibuf=%h cbuf=%h want 0/0/8", bus.busy, bus.ibuf, bus.cbuf);
      end
      bus.keys = 16'h0;
      tick();
      press_digit(4); press_op(0); press_digit(1);
      bus.equal = 1'b1;
      tick();
      bus.equal = 1'b0;
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      total++;
      if ({bus.ibuf, bus.cbuf, bus.ovf, bus.busy} !== 66'd0) begin
         bad++;
         $display("FAIL clear_busy: got ibuf=%h cbuf=%h ovf=%b busy=%b want all 0",
                  bus.ibuf, bus.cbuf, bus.ovf, bus.busy);
      end
      tick(); tick();
      m_clear();
      press_digit(2); press_op(0);
      total++;
      if (bus.cbuf !== 32'h2 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL clear_to_idle: got cbuf=%h busy=%b want 2/0", bus.cbuf, bus.busy);
      end
   endtask

   task automatic test_random();
      int r;
      for (int it = 0; it < 150; it++) begin
         r = int'($urandom_range(0, 19));
         if (r < 12)      press_digit(int'($urandom_range(0, 15)));
         else if (r < 19) press_op(int'($urandom_range(0, 2)));
         else             press_clear();
         total++;
         if (bus.ibuf !== m_ibuf || bus.cbuf !== m_cbuf || bus.ovf !== m_ovf) begin
            bad++;
            $display("FAIL random_%0d: got ibuf=%h cbuf=%h ovf=%b want %h/%h/%b",
                     it, bus.ibuf, bus.cbuf, bus.ovf, m_ibuf, m_cbuf, m_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_digits();
      test_add();
      test_overflow();
      test_limit_priority();
      test_clear_busy();
      press_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
